// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED counter controller and its datapath:
// sequencer state encodings and tick-rate select codes.
package led_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_CLEAR = 2'b11
  } state_t;

  localparam int SPEED_W = 2;
  typedef logic [SPEED_W-1:0] speed_t;

  // Tick period is the 1 s period shifted right by the select code.
  localparam speed_t SPEED_1S     = 2'd0;
  localparam speed_t SPEED_HALF_S = 2'd1;
  localparam speed_t SPEED_QTR_S  = 2'd2;
  localparam speed_t SPEED_8TH_S  = 2'd3;

  function automatic speed_t next_speed(input speed_t cur);
    return cur + speed_t'(1);
  endfunction

endpackage

// File: rtl/led_counter_sequencer_btn_debouncer.sv
// Two-flop synchroniser followed by a run-length debouncer; the level only
// flips after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debouncer #(
  parameter int DEBOUNCE_CYCLES = 120_000
) (
  input  logic CLK,
  input  logic RST,
  input  logic RAW,
  output logic LEVEL,
  output logic RISE,
  output logic FALL
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      LEVEL <= 1'b0;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= RAW;
      sync2 <= sync1;
      RISE  <= 1'b0;
      FALL  <= 1'b0;
      // Any agreeing sample restarts the run, so bounces never accumulate.
      if (sync2 != LEVEL) begin
        if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          LEVEL <= sync2;
          RISE  <= sync2;
          FALL  <= ~sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/led_counter_sequencer.sv
// Run/pause/clear sequencer for the 8-bit LED counter: debounces the three
// buttons, decodes short/long presses and generates the advance tick.
module led_counter_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int ONE_SEC_LIMIT     = 12_000_000,
  parameter int DEBOUNCE_CYCLES   = 120_000,
  parameter int LONG_PRESS_CYCLES = 18_000_000
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               BTN_RUN,
  input  logic               BTN_SPEED,
  input  logic               BTN_DIR,
  output logic               CNT_TICK,
  output logic               CNT_CLR,
  output logic               CNT_UP,
  output logic [SPEED_W-1:0] SPEED_SEL,
  output logic [1:0]         STATE
);

  localparam int PRESC_W = $clog2(ONE_SEC_LIMIT);
  localparam int HOLD_W  = $clog2(LONG_PRESS_CYCLES + 1);

  logic run_level, run_rise, run_fall;
  logic speed_level, speed_rise, speed_fall;
  logic dir_level, dir_rise, dir_fall;

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
    .CLK   (CLK),
    .RST   (RST),
    .RAW   (BTN_RUN),
    .LEVEL (run_level),
    .RISE  (run_rise),
    .FALL  (run_fall)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_speed (
    .CLK   (CLK),
    .RST   (RST),
    .RAW   (BTN_SPEED),
    .LEVEL (speed_level),
    .RISE  (speed_rise),
    .FALL  (speed_fall)
  );

  btn_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dir (
    .CLK   (CLK),
    .RST   (RST),
    .RAW   (BTN_DIR),
    .LEVEL (dir_level),
    .RISE  (dir_rise),
    .FALL  (dir_fall)
  );

  logic unused_btn_edges;
  assign unused_btn_edges = &{1'b0, run_rise, speed_level, speed_fall, dir_level, dir_fall};

  // Long-press tracker: hold time counts only while the debounced level is
  // high and freezes once LONG has fired, so one press yields one LONG.
  logic [HOLD_W-1:0] hold_cnt;
  logic              long_fired;
  logic              long_evt;
  logic              short_evt;

  assign long_evt  = run_level && !long_fired && (hold_cnt == HOLD_W'(LONG_PRESS_CYCLES - 1));
  assign short_evt = run_fall && !long_fired;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_cnt   <= '0;
      long_fired <= 1'b0;
    end else if (!run_level) begin
      hold_cnt   <= '0;
      long_fired <= 1'b0;
    end else begin
      if (!long_fired && !long_evt) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      long_fired <= long_fired | long_evt;
    end
  end

  state_t               state, state_next;
  logic [PRESC_W-1:0]   presc, presc_next;
  logic [PRESC_W-1:0]   period_m1;
  speed_t               speed, speed_next;
  logic                 up_next;
  logic                 tick_next;
  logic                 clr_next;

  always_comb begin
    period_m1 = PRESC_W'((ONE_SEC_LIMIT >> speed) - 1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= ST_IDLE;
      presc    <= '0;
      speed    <= SPEED_1S;
      CNT_UP   <= 1'b1;
      CNT_TICK <= 1'b0;
      CNT_CLR  <= 1'b0;
    end else begin
      state    <= state_next;
      presc    <= presc_next;
      speed    <= speed_next;
      CNT_UP   <= up_next;
      CNT_TICK <= tick_next;
      CNT_CLR  <= clr_next;
    end
  end

  // Next state and registered outputs; overrides below the case apply the
  // priority LONG/CLEAR over speed change over tick.
  always_comb begin
    state_next = state;
    presc_next = presc;
    speed_next = speed;
    up_next    = CNT_UP ^ dir_rise;
    tick_next  = 1'b0;
    clr_next   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        presc_next = '0;
        if (long_evt) begin
          state_next = ST_CLEAR;
        end else if (short_evt) begin
          state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (long_evt) begin
          state_next = ST_CLEAR;
        end else begin
          if (short_evt) begin
            state_next = ST_PAUSE;
          end
          if (presc == period_m1) begin
            presc_next = '0;
            tick_next  = 1'b1;
          end else begin
            presc_next = presc + PRESC_W'(1);
          end
        end
      end
      ST_PAUSE: begin
        if (long_evt) begin
          state_next = ST_CLEAR;
        end else if (short_evt) begin
          state_next = ST_RUN;
        end
      end
      ST_CLEAR: begin
        presc_next = '0;
        state_next = ST_IDLE;
      end
      default: begin
        presc_next = '0;
        state_next = ST_IDLE;
      end
    endcase

    if (speed_rise) begin
      speed_next = next_speed(speed);
      presc_next = '0;
      tick_next  = 1'b0;
    end

    if (state_next == ST_CLEAR) begin
      presc_next = '0;
      tick_next  = 1'b0;
      clr_next   = 1'b1;
    end
  end

  assign SPEED_SEL = speed;
  assign STATE     = state;

endmodule

// File: tb/tb_led_counter_sequencer.sv
// Directed self-checking bench for led_counter_sequencer with shortened
// timing constants (1 s = 16 cycles, debounce = 4, long press = 40).
module tb_led_counter_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN_RUN, BTN_SPEED, BTN_DIR;
  logic       CNT_TICK, CNT_CLR, CNT_UP;
  logic [1:0] SPEED_SEL;
  logic [1:0] STATE;

  int checks = 0;
  int passed = 0;
  int failed = 0;

  led_counter_sequencer #(
    .ONE_SEC_LIMIT     (16),
    .DEBOUNCE_CYCLES   (4),
    .LONG_PRESS_CYCLES (40)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .BTN_RUN   (BTN_RUN),
    .BTN_SPEED (BTN_SPEED),
    .BTN_DIR   (BTN_DIR),
    .CNT_TICK  (CNT_TICK),
    .CNT_CLR   (CNT_CLR),
    .CNT_UP    (CNT_UP),
    .SPEED_SEL (SPEED_SEL),
    .STATE     (STATE)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500us;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic run, input logic speed, input logic dir);
    BTN_RUN   = run;
    BTN_SPEED = speed;
    BTN_DIR   = dir;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) passed++;
    else begin
      failed++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic waitState(input logic [1:0] s, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (STATE === s) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic waitTick(input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (CNT_TICK === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic waitSpeed(input logic [1:0] s, input int max, output int n);
    n = -1;
    for (int i = 1; i <= max; i++) begin
      step(1);
      if (SPEED_SEL === s) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic countTicks(input int cycles, output int ticks);
    ticks = 0;
    for (int i = 0; i < cycles; i++) begin
      step(1);
      if (CNT_TICK !== 1'b0) ticks++;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_state"}, 32'(STATE), 32'd0);
    checkOutput({tag, "_tick"},  32'(CNT_TICK), 32'd0);
    checkOutput({tag, "_clr"},   32'(CNT_CLR), 32'd0);
    checkOutput({tag, "_up"},    32'(CNT_UP), 32'd1);
    checkOutput({tag, "_speed"}, 32'(SPEED_SEL), 32'd0);
  endtask

  initial begin
    int n;
    int ticks;
    int noise;
    logic [1:0] sel;
    int period;

    RST = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(3);
    checkResetValues("reset");
    RST = 1'b0;

    // Idle with no buttons: nothing moves.
    noise = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (CNT_TICK !== 1'b0 || CNT_CLR !== 1'b0) noise++;
    end
    checkOutput("idle_quiet", 32'(noise), 32'd0);
    checkResetValues("idle");

    // Three-cycle glitch is filtered out.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(20);
    checkOutput("glitch_idle_state", 32'(STATE), 32'd0);

    // Short press starts RUN; ticks every 16 cycles.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitState(2'b01, 30, n);
    checkOutput("run_entry_delay", 32'(n), 32'd7);
    waitTick(40, n);
    checkOutput("run_first_tick", 32'(n), 32'd16);
    waitTick(40, n);
    checkOutput("run_tick_spacing", 32'(n), 32'd16);

    applyStimulus(1'b1, 1'b1, 1'b1);
    step(3);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitTick(40, n);
    checkOutput("glitch_run_tick", 32'(n), 32'd13);
    checkOutput("glitch_run_state", 32'(STATE), 32'd1);
    checkOutput("glitch_speed", 32'(SPEED_SEL), 32'd0);
    checkOutput("glitch_dir", 32'(CNT_UP), 32'd1);

    // SHORT lands with prescaler at 9: pause, then resume finishes period.
    step(9);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitState(2'b10, 30, n);
    checkOutput("pause_entry_delay", 32'(n), 32'd7);
    countTicks(40, ticks);
    checkOutput("pause_no_ticks", 32'(ticks), 32'd0);
    checkOutput("pause_state", 32'(STATE), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitState(2'b01, 30, n);
    checkOutput("resume_entry_delay", 32'(n), 32'd7);
    waitTick(40, n);
    checkOutput("resume_first_tick", 32'(n), 32'd6);
    waitTick(40, n);
    checkOutput("resume_tick_spacing", 32'(n), 32'd16);

    // Speed cycles 1,2,3,0 with periods 8,4,2,16.
    sel = 2'd0;
    for (int k = 0; k < 4; k++) begin
      sel = sel + 2'd1;
      period = (sel == 2'd1) ? 8 : (sel == 2'd2) ? 4 : (sel == 2'd3) ? 2 : 16;
      step(10);
      applyStimulus(1'b0, 1'b1, 1'b0);
      step(6);
      applyStimulus(1'b0, 1'b0, 1'b0);
      waitSpeed(sel, 20, n);
      checkOutput($sformatf("speed%0d_update", k), 32'(n), 32'd1);
      waitTick(40, n);
      checkOutput($sformatf("speed%0d_first", k), 32'(n), 32'(period));
      waitTick(40, n);
      checkOutput($sformatf("speed%0d_spacing", k), 32'(n), 32'(period));
    end

    // Speed rise on the would-be tick cycle suppresses that tick.
    step(9);
    applyStimulus(1'b0, 1'b1, 1'b0);
    step(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    step(1);
    checkOutput("collide_speed", 32'(SPEED_SEL), 32'd1);
    checkOutput("collide_tick_absent", 32'(CNT_TICK), 32'd0);
    waitTick(40, n);
    checkOutput("collide_next_tick", 32'(n), 32'd8);

    // 60-cycle hold: LONG fires, one CLEAR cycle, release does nothing.
    applyStimulus(1'b1, 1'b0, 1'b0);
    waitState(2'b11, 80, n);
    checkOutput("long_clear_delay", 32'(n), 32'd46);
    checkOutput("long_clr_pulse", 32'(CNT_CLR), 32'd1);
    checkOutput("long_tick_low", 32'(CNT_TICK), 32'd0);
    step(1);
    checkOutput("long_idle_state", 32'(STATE), 32'd0);
    checkOutput("long_clr_single", 32'(CNT_CLR), 32'd0);
    countTicks(13, ticks);
    applyStimulus(1'b0, 1'b0, 1'b0);
    noise = 0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      if (CNT_TICK !== 1'b0) ticks++;
      if (STATE !== 2'b00 || CNT_CLR !== 1'b0) noise++;
    end
    checkOutput("long_no_ticks", 32'(ticks), 32'd0);
    checkOutput("long_release_no_short", 32'(noise), 32'd0);
    checkOutput("long_keeps_speed", 32'(SPEED_SEL), 32'd1);

    // Direction toggle while running, then reset mid-run.
    applyStimulus(1'b1, 1'b0, 1'b0);
    step(10);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitState(2'b01, 30, n);
    checkOutput("rerun_entry_delay", 32'(n), 32'd7);
    waitTick(40, n);
    checkOutput("rerun_first_tick", 32'(n), 32'd8);
    step(2);
    applyStimulus(1'b0, 1'b0, 1'b1);
    step(6);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("dir_before_flip", 32'(CNT_UP), 32'd1);
    step(1);
    checkOutput("dir_flipped", 32'(CNT_UP), 32'd0);
    waitTick(40, n);
    checkOutput("dir_no_forced_tick", 32'(n), 32'd7);
    waitTick(40, n);
    checkOutput("dir_tick_spacing", 32'(n), 32'd8);
    checkOutput("dir_held", 32'(CNT_UP), 32'd0);

    step(3);
    RST = 1'b1;
    step(1);
    checkResetValues("midrun_reset");
    RST = 1'b0;
    countTicks(20, ticks);
    checkOutput("post_reset_ticks", 32'(ticks), 32'd0);
    checkOutput("post_reset_state", 32'(STATE), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
